// File: rtl/shared_pkg.sv
// Constants and types shared by the FIFO RTL and its verification environment.
package shared_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WR,
    OP_RD,
    OP_WR_RD
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// DATA_WIDTH x FIFO_DEPTH register file: one synchronous write port and one
// combinational read port. Contents are not reset.
module fifo_mem #(
  parameter int  DATA_WIDTH = shared_pkg::FIFO_WIDTH,
  parameter int  FIFO_DEPTH = shared_pkg::FIFO_DEPTH,
  localparam int AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost
// flags, synchronous flush and selectable registered / FWFT read mode.
module fifo_param #(
  parameter int  DATA_WIDTH = shared_pkg::FIFO_WIDTH,
  parameter int  FIFO_DEPTH = shared_pkg::FIFO_DEPTH,
  parameter int  AF_THRESH  = FIFO_DEPTH - 1,
  parameter int  AE_THRESH  = 1,
  parameter bit  FWFT       = 1'b0,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0] LAST    = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (!(FIFO_DEPTH >= 2 && AE_THRESH >= 0 && AE_THRESH < AF_THRESH &&
        AF_THRESH <= FIFO_DEPTH)) begin : g_bad_params
    $error("fifo_param: need FIFO_DEPTH>=2 and 0<=AE_THRESH<AF_THRESH<=FIFO_DEPTH");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] rd_word, dout_q;
  logic                  wr_acc, rd_acc;

  // Explicit wrap at FIFO_DEPTH-1 so non-power-of-2 depths work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= AF_C);
  assign almostempty = (count_q <= AE_C);
  assign count       = count_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc && !flush),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      dout_q    <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      dout_q    <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
      if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
      if (rd_acc) begin
        rd_ptr <= next_ptr(rd_ptr);
        dout_q <= rd_word;
      end
      if (wr_acc && !rd_acc)      count_q <= count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_q <= count_q - CW'(1);
    end
  end

  // FWFT presents the head entry directly; standard mode uses the registered copy.
  assign data_out = FWFT ? rd_word : dout_q;

endmodule
